ringosc_meas_ctrl: RTL

//  Clocked measurement sequencer that drives the ring-oscillator counter interface: {reset, stop, shift[5:0]} out, cnt[7:0] in.

---
 rtl/ringosc_meas_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement sequencer: clears the counter, opens a gate
// window of a programmed length, freezes the count, then reads the wide
// count back one byte at a time through the counter's shift select.
module ringosc_meas_ctrl #(
    parameter int GATE_W    = 16,
    parameter int NUM_BYTES = 4,
    parameter int SETTLE    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [GATE_W-1:0]      gate_len_i,
    input  logic [5:0]             shift_base_i,
    output logic                   osc_reset_o,
    output logic                   osc_stop_o,
    output logic [5:0]             osc_shift_o,
    input  logic [7:0]             osc_cnt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [8*NUM_BYTES-1:0] result_o,
    output logic                   result_valid_o
);

    localparam int RES_W = 8 * NUM_BYTES;
    localparam int TMR_W = $clog2(SETTLE + 2);
    localparam int IDX_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FREEZE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state;
    logic [GATE_W-1:0] gate_len;
    logic [GATE_W-1:0] gate_cnt;
    logic [5:0]        shift_base;
    logic [TMR_W-1:0]  tmr;
    logic [IDX_W-1:0]  byte_idx;
    logic [RES_W-1:0]  byte_buf;
    logic [7:0]        cnt_p0;
    logic [7:0]        cnt_p1;

    // Bytes enter at the top and move down, so the first byte read ends up in byte 0.
    function automatic logic [RES_W-1:0] capture_byte(input logic [RES_W-1:0] acc,
                                                      input logic [7:0] b);
        return (acc >> 8) | (RES_W'(b) << (RES_W - 8));
    endfunction

    // Two-flop synchroniser for the asynchronous counter byte.
    always_ff @(posedge clk) begin
        cnt_p0 <= osc_cnt_i;
        cnt_p1 <= cnt_p0;
    end

    // Measurement sequencer with registered counter-control and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            osc_reset_o    <= 1'b1;
            osc_stop_o     <= 1'b1;
            osc_shift_o    <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            gate_len       <= '0;
            gate_cnt       <= '0;
            shift_base     <= '0;
            tmr            <= '0;
            byte_idx       <= '0;
            byte_buf       <= '0;
        end else begin
            done_o <= 1'b0;
            if (abort_i && state != S_IDLE) begin
                state          <= S_IDLE;
                osc_reset_o    <= 1'b0;
                osc_stop_o     <= 1'b1;
                busy_o         <= 1'b0;
                result_valid_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        osc_reset_o <= 1'b0;
                        osc_stop_o  <= 1'b1;
                        if (start_i) begin
                            gate_len       <= gate_len_i;
                            shift_base     <= shift_base_i;
                            result_valid_o <= 1'b0;
                            osc_reset_o    <= 1'b1;
                            busy_o         <= 1'b1;
                            tmr            <= '0;
                            state          <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        if (tmr == TMR_W'(1)) begin
                            tmr         <= '0;
                            osc_reset_o <= 1'b0;
                            gate_cnt    <= '0;
                            if (gate_len == '0) begin
                                state <= S_FREEZE;
                            end else begin
                                osc_stop_o <= 1'b0;
                                state      <= S_RUN;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (gate_cnt == gate_len - GATE_W'(1)) begin
                            osc_stop_o <= 1'b1;
                            tmr        <= '0;
                            state      <= S_FREEZE;
                        end else begin
                            gate_cnt <= gate_cnt + GATE_W'(1);
                        end
                    end
                    S_FREEZE: begin
                        if (tmr == TMR_W'(SETTLE - 1)) begin
                            tmr         <= '0;
                            byte_idx    <= '0;
                            osc_shift_o <= shift_base;
                            state       <= S_READ;
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_READ: begin
                        if (tmr == TMR_W'(SETTLE + 1)) begin
                            byte_buf <= capture_byte(byte_buf, cnt_p1);
                            tmr      <= '0;
                            if (byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                                result_o       <= capture_byte(byte_buf, cnt_p1);
                                result_valid_o <= 1'b1;
                                done_o         <= 1'b1;
                                state          <= S_DONE;
                            end else begin
                                byte_idx    <= byte_idx + IDX_W'(1);
                                osc_shift_o <= osc_shift_o + 6'd8;
                            end
                        end else begin
                            tmr <= tmr + TMR_W'(1);
                        end
                    end
                    S_DONE: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
